// File: rtl/mqnic_l2_pfc_tx_sched_if.sv
// rtl/mqnic_l2_pfc_tx_sched_if.sv - MAC-control-frame request bundle between scheduler and MCF generator
//
// master: scheduler side (drives the request, samples mcf_ready)
// slave : frame generator side
//   mcf_valid/mcf_ready   request handshake
//   mcf_eth_dst/src       frame addresses
//   mcf_eth_type          EtherType (0x8808)
//   mcf_opcode            MAC control opcode
//   mcf_params            opcode parameters, byte k = [8k+7:8k], byte 0 first on the wire
//   mcf_id/dest/user      sideband tags
interface mqnic_l2_pfc_tx_sched_if #(
    parameter int MCF_PARAMS_SIZE = 18,
    parameter int ID_WIDTH        = 8,
    parameter int DEST_WIDTH      = 8,
    parameter int USER_WIDTH      = 1
);
    logic                         mcf_valid;
    logic                         mcf_ready;
    logic [47:0]                  mcf_eth_dst;
    logic [47:0]                  mcf_eth_src;
    logic [15:0]                  mcf_eth_type;
    logic [15:0]                  mcf_opcode;
    logic [MCF_PARAMS_SIZE*8-1:0] mcf_params;
    logic [ID_WIDTH-1:0]          mcf_id;
    logic [DEST_WIDTH-1:0]        mcf_dest;
    logic [USER_WIDTH-1:0]        mcf_user;

    modport master (
        output mcf_valid, mcf_eth_dst, mcf_eth_src, mcf_eth_type, mcf_opcode,
               mcf_params, mcf_id, mcf_dest, mcf_user,
        input  mcf_ready
    );

    modport slave (
        input  mcf_valid, mcf_eth_dst, mcf_eth_src, mcf_eth_type, mcf_opcode,
               mcf_params, mcf_id, mcf_dest, mcf_user,
        output mcf_ready
    );
endinterface

// File: rtl/mqnic_l2_pfc_tx_sched.sv
// rtl/mqnic_l2_pfc_tx_sched.sv - PFC/LFC pause frame request scheduler
//
// Turns per-class congestion flags into 802.1Qbb PFC (or 802.3x LFC) pause/resume
// frame requests, batching all classes pending at launch into one frame and
// refreshing XOFF before the peer's pause quanta run out.
//
// Optional build macro: MQNIC_PFC_SCHED_LFC_EN - when defined, cfg_lfc_mode selects
// LFC framing; otherwise only PFC frames are produced and cfg_lfc_mode is ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   xoff_req          per-class congestion level (1 = pause peer)
//   cfg_enable        scheduler enable
//   cfg_lfc_mode      1 = LFC (opcode 0x0001), 0 = PFC (opcode 0x0101)
//   cfg_eth_dst/src   frame addresses, captured at launch
//   cfg_quanta        pause time sent for paused classes
//   cfg_refresh       refresh interval in prescaler ticks, 0 = no refresh
//   stat_tx_xoff/xon  one-cycle pulses on accept of a frame with a nonzero/zero time
//   mcf               frame request bundle (master side)
module mqnic_l2_pfc_tx_sched #(
    parameter int PRIOS           = 8,
    parameter int PRESCALE        = 512,
    parameter int MCF_PARAMS_SIZE = 18,
    parameter int ID_WIDTH        = 8,
    parameter int DEST_WIDTH      = 8,
    parameter int USER_WIDTH      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PRIOS-1:0]  xoff_req,
    input  logic              cfg_enable,
    input  logic              cfg_lfc_mode,
    input  logic [47:0]       cfg_eth_dst,
    input  logic [47:0]       cfg_eth_src,
    input  logic [15:0]       cfg_quanta,
    input  logic [15:0]       cfg_refresh,
    output logic              stat_tx_xoff,
    output logic              stat_tx_xon,
    mqnic_l2_pfc_tx_sched_if.master mcf
);
    localparam int PB = MCF_PARAMS_SIZE * 8;
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic lfc_mode;
`ifdef MQNIC_PFC_SCHED_LFC_EN
    assign lfc_mode = cfg_lfc_mode;
`else
    assign lfc_mode = 1'b0;
    logic unused_cfg_lfc_mode;
    assign unused_cfg_lfc_mode = cfg_lfc_mode;
`endif

    logic [0:0]       state;
    logic [PRIOS-1:0] xoff_prev;
    logic [PRIOS-1:0] pending;
    logic [PRIOS-1:0] sent_xoff;     // classes the in-flight frame pauses; reload their refresh on accept
    logic             frame_xoff;
    logic             frame_xon;
    logic [15:0]      refresh_cnt [PRIOS];
    logic [PW-1:0]    prescale_cnt;

    logic [PRIOS-1:0] xoff_cur;
    logic [PRIOS-1:0] active_cls;
    logic [PRIOS-1:0] change;
    logic [PRIOS-1:0] expire;
    logic [PRIOS-1:0] pending_set;
    logic             any_prev;
    logic             any_cur;
    logic             tick;
    logic             accept;
    logic             launch;

    logic [PB-1:0]    params_next;
    logic [PRIOS-1:0] sent_next;
    logic             xoff_next;
    logic             xon_next;
    logic [15:0]      cls_time;

    // Disabling forces the reference level to zero, so re-enabling with a class
    // still congested looks like a fresh edge and issues XOFF.
    assign xoff_cur = cfg_enable ? xoff_req : '0;
    assign any_prev = |xoff_prev;
    assign any_cur  = |xoff_cur;
    assign tick     = (prescale_cnt == PW'(PRESCALE - 1));
    assign accept   = (state == ST_SEND) && mcf.mcf_ready;
    assign launch   = (state == ST_IDLE) && cfg_enable && (|pending);

    // LFC collapses everything onto class 0: one aggregate level, one refresh timer.
    assign active_cls = lfc_mode ? {{(PRIOS-1){1'b0}}, any_prev} : xoff_prev;
    assign change     = lfc_mode ? {{(PRIOS-1){1'b0}}, any_cur != any_prev} : (xoff_cur ^ xoff_prev);

    always_comb begin
        expire = '0;
        for (int i = 0; i < PRIOS; i++) begin
            expire[i] = (cfg_refresh != 16'd0) && tick && active_cls[i] && (refresh_cnt[i] == 16'd1);
        end
    end

    assign pending_set = change | expire;

    // Frame contents derived from the levels as they stand at launch.
    always_comb begin
        params_next = '0;
        sent_next   = '0;
        xoff_next   = 1'b0;
        xon_next    = 1'b0;
        cls_time    = '0;
        if (lfc_mode) begin
            cls_time          = any_prev ? cfg_quanta : 16'd0;
            params_next[7:0]  = cls_time[15:8];
            params_next[15:8] = cls_time[7:0];
            sent_next[0]      = any_prev;
            xoff_next         = (cls_time != 16'd0);
            xon_next          = (cls_time == 16'd0);
        end else begin
            params_next[15:8] = pending;
            for (int i = 0; i < PRIOS; i++) begin
                if (pending[i]) begin
                    cls_time = xoff_prev[i] ? cfg_quanta : 16'd0;
                    params_next[(2 + 2 * i) * 8 +: 8] = cls_time[15:8];
                    params_next[(3 + 2 * i) * 8 +: 8] = cls_time[7:0];
                    sent_next[i] = xoff_prev[i];
                    if (cls_time != 16'd0) begin
                        xoff_next = 1'b1;
                    end else begin
                        xon_next = 1'b1;
                    end
                end
            end
        end
    end

    assign mcf.mcf_eth_type = 16'h8808;
    assign mcf.mcf_id       = '0;
    assign mcf.mcf_dest     = '0;
    assign mcf.mcf_user     = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            mcf.mcf_valid    <= 1'b0;
            mcf.mcf_params   <= '0;
            mcf.mcf_opcode   <= 16'h0101;
            mcf.mcf_eth_dst  <= '0;
            mcf.mcf_eth_src  <= '0;
            stat_tx_xoff     <= 1'b0;
            stat_tx_xon      <= 1'b0;
            xoff_prev        <= '0;
            pending          <= '0;
            sent_xoff        <= '0;
            frame_xoff       <= 1'b0;
            frame_xon        <= 1'b0;
            prescale_cnt     <= '0;
            for (int i = 0; i < PRIOS; i++) begin
                refresh_cnt[i] <= '0;
            end
        end else begin
            xoff_prev    <= xoff_cur;
            prescale_cnt <= tick ? '0 : prescale_cnt + PW'(1);
            stat_tx_xoff <= accept && frame_xoff;
            stat_tx_xon  <= accept && frame_xon;

            // Reload on accept takes precedence over the tick; an expiry on the same
            // edge still raises pending through expire.
            for (int i = 0; i < PRIOS; i++) begin
                if (cfg_refresh == 16'd0) begin
                    refresh_cnt[i] <= '0;
                end else if (accept && sent_xoff[i]) begin
                    refresh_cnt[i] <= cfg_refresh;
                end else if (tick && active_cls[i] && refresh_cnt[i] != 16'd0) begin
                    refresh_cnt[i] <= refresh_cnt[i] - 16'd1;
                end
            end

            // Launch snapshots all of pending, so only same-edge events survive it.
            if (!cfg_enable) begin
                pending <= '0;
            end else if (launch) begin
                pending <= pending_set;
            end else begin
                pending <= pending | pending_set;
            end

            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state           <= ST_SEND;
                        mcf.mcf_valid   <= 1'b1;
                        mcf.mcf_params  <= params_next;
                        mcf.mcf_opcode  <= lfc_mode ? 16'h0001 : 16'h0101;
                        mcf.mcf_eth_dst <= cfg_eth_dst;
                        mcf.mcf_eth_src <= cfg_eth_src;
                        sent_xoff       <= sent_next;
                        frame_xoff      <= xoff_next;
                        frame_xon       <= xon_next;
                    end
                end
                default: begin
                    if (mcf.mcf_ready) begin
                        state         <= ST_IDLE;
                        mcf.mcf_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mqnic_l2_pfc_tx_sched.sv
// tb/tb_mqnic_l2_pfc_tx_sched.sv - self-checking bench for mqnic_l2_pfc_tx_sched
module tb_mqnic_l2_pfc_tx_sched;
    localparam int PRESC = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  xoff_req;
    logic        cfg_enable;
    logic        cfg_lfc_mode;
    logic [47:0] cfg_eth_dst;
    logic [47:0] cfg_eth_src;
    logic [15:0] cfg_quanta;
    logic [15:0] cfg_refresh;
    logic        stat_tx_xoff;
    logic        stat_tx_xon;

    int tests_run    = 0;
    int tests_failed = 0;

    mqnic_l2_pfc_tx_sched_if #(.MCF_PARAMS_SIZE(18), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) mcf_bus ();

    mqnic_l2_pfc_tx_sched #(
        .PRIOS(8), .PRESCALE(PRESC), .MCF_PARAMS_SIZE(18),
        .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .xoff_req     (xoff_req),
        .cfg_enable   (cfg_enable),
        .cfg_lfc_mode (cfg_lfc_mode),
        .cfg_eth_dst  (cfg_eth_dst),
        .cfg_eth_src  (cfg_eth_src),
        .cfg_quanta   (cfg_quanta),
        .cfg_refresh  (cfg_refresh),
        .stat_tx_xoff (stat_tx_xoff),
        .stat_tx_xon  (stat_tx_xon),
        .mcf          (mcf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: pending events, outstanding frame, refresh timers
    bit [7:0]    m_prev;
    bit [7:0]    m_pend;
    int          m_cnt [8];
    int          m_presc;
    bit          m_busy;
    bit [7:0]    m_sent;
    bit          m_fx;
    bit          m_fn;
    bit          m_sx;
    bit          m_sn;
    logic [143:0] m_params;
    logic [15:0] m_op;
    logic [47:0] m_dst;
    logic [47:0] m_src;

    function automatic bit model_lfc();
`ifdef MQNIC_PFC_SCHED_LFC_EN
        return cfg_lfc_mode;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_presc = 0; m_busy = 0; m_sent = '0;
        m_fx = 0; m_fn = 0; m_sx = 0; m_sn = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    task automatic model_build(input bit lfc);
        bit [7:0] b [18];
        int       t;
        for (int k = 0; k < 18; k++) b[k] = 8'h00;
        m_sent = '0; m_fx = 0; m_fn = 0;
        if (lfc) begin
            t = (m_prev != 0) ? int'(cfg_quanta) : 0;
            b[0] = 8'(t >> 8); b[1] = 8'(t);
            m_sent[0] = (m_prev != 0);
            if (t != 0) m_fx = 1; else m_fn = 1;
        end else begin
            b[1] = m_pend;
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i]) begin
                    t = m_prev[i] ? int'(cfg_quanta) : 0;
                    b[2 + 2 * i] = 8'(t >> 8);
                    b[3 + 2 * i] = 8'(t);
                    m_sent[i] = m_prev[i];
                    if (t != 0) m_fx = 1; else m_fn = 1;
                end
            end
        end
        for (int k = 0; k < 18; k++) m_params[8 * k +: 8] = b[k];
        m_op  = lfc ? 16'h0001 : 16'h0101;
        m_dst = cfg_eth_dst;
        m_src = cfg_eth_src;
    endtask

    task automatic model_edge();
        bit       acc;
        bit       lfc;
        bit       tick;
        bit       act;
        bit [7:0] cur;
        bit [7:0] ev;
        lfc  = model_lfc();
        acc  = m_busy && mcf_bus.mcf_ready;
        m_sx = acc && m_fx;
        m_sn = acc && m_fn;
        cur  = cfg_enable ? xoff_req : 8'h00;
        ev   = '0;
        if (lfc) ev[0] = ((m_prev != 0) != (cur != 0));
        else     ev = cur ^ m_prev;
        tick    = (m_presc == PRESC - 1);
        m_presc = (m_presc + 1) % PRESC;
        for (int i = 0; i < 8; i++) begin
            act = lfc ? (i == 0 && m_prev != 0) : m_prev[i];
            if (cfg_refresh == 0) begin
                m_cnt[i] = 0;
            end else begin
                if (tick && act && m_cnt[i] == 1) ev[i] = 1;
                if (acc && m_sent[i])                m_cnt[i] = int'(cfg_refresh);
                else if (tick && act && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
        end
        if (!m_busy && cfg_enable && m_pend != 0) begin
            model_build(lfc);
            m_busy = 1;
            m_pend = '0;
        end else if (acc) begin
            m_busy = 0;
        end
        m_pend = cfg_enable ? (m_pend | ev) : 8'h00;
        m_prev = cur;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_edge();
    end

    always @(negedge clk) begin
        check("valid", 144'(mcf_bus.mcf_valid), 144'(m_busy));
        check("stat_xoff", 144'(stat_tx_xoff), 144'(m_sx));
        check("stat_xon", 144'(stat_tx_xon), 144'(m_sn));
        if (m_busy && mcf_bus.mcf_valid) begin
            check("params", mcf_bus.mcf_params, m_params);
            check("opcode", 144'(mcf_bus.mcf_opcode), 144'(m_op));
            check("eth_dst", 144'(mcf_bus.mcf_eth_dst), 144'(m_dst));
            check("eth_src", 144'(mcf_bus.mcf_eth_src), 144'(m_src));
            check("eth_type", 144'(mcf_bus.mcf_eth_type), 144'(16'h8808));
            check("sideband", 144'({mcf_bus.mcf_id, mcf_bus.mcf_dest, mcf_bus.mcf_user}), 144'(0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!mcf_bus.mcf_valid && k < budget) begin
            step(1);
            k++;
        end
        if (!mcf_bus.mcf_valid) check(tag, 144'(0), 144'(1));
    endtask

    int acc_idx [5];
    int n_acc;
    int cyc;
    int n_valid;

    initial begin
        rst = 1'b1; cfg_enable = 1'b0; cfg_lfc_mode = 1'b0; xoff_req = 8'h00;
        cfg_eth_dst = 48'h0180C2000001; cfg_eth_src = 48'h020000000001;
        cfg_quanta = 16'hFFFF; cfg_refresh = 16'd0; mcf_bus.mcf_ready = 1'b0;
        step(3);
        rst = 1'b0;
        check("rst_valid", 144'(mcf_bus.mcf_valid), 144'(0));
        check("rst_opcode", 144'(mcf_bus.mcf_opcode), 144'(16'h0101));
        check("rst_params", mcf_bus.mcf_params, 144'(0));
        check("rst_stats", 144'({stat_tx_xoff, stat_tx_xon}), 144'(0));

        // single class XOFF, two-cycle latency
        cfg_enable = 1'b1; xoff_req = 8'h04;
        step(1);
        check("t1_lat1", 144'(mcf_bus.mcf_valid), 144'(0));
        step(1);
        check("t1_valid", 144'(mcf_bus.mcf_valid), 144'(1));
        check("t1_opcode", 144'(mcf_bus.mcf_opcode), 144'(16'h0101));
        check("t1_params", mcf_bus.mcf_params, 144'(64'hFFFF_0000_0000_0400));
        mcf_bus.mcf_ready = 1'b1;
        step(1);
        check("t1_stat_xoff", 144'(stat_tx_xoff), 144'(1));

        // XON for the same class
        xoff_req = 8'h00;
        step(2);
        check("t2_params", mcf_bus.mcf_params, 144'(16'h0400));
        step(1);
        check("t2_stat_xon", 144'(stat_tx_xon), 144'(1));
        step(3);

        // backpressure: request held stable, later event batched into next frame
        mcf_bus.mcf_ready = 1'b0; xoff_req = 8'h01;
        wait_valid("t3_timeout1", 10);
        check("t3_first", mcf_bus.mcf_params, 144'(32'hFFFF_0100));
        xoff_req = 8'h81;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t3_hold", mcf_bus.mcf_params, 144'(32'hFFFF_0100));
        end
        mcf_bus.mcf_ready = 1'b1;
        step(1);
        wait_valid("t3_timeout2", 10);
        check("t3_second", mcf_bus.mcf_params, {16'hFFFF, 112'h0, 16'h8000});
        step(1);
        xoff_req = 8'h00;
        step(10);

        // reset while requesting
        mcf_bus.mcf_ready = 1'b0; xoff_req = 8'h01;
        wait_valid("t6_timeout1", 10);
        rst = 1'b1; xoff_req = 8'h02;
        step(1);
        check("t6_rst_drop", 144'(mcf_bus.mcf_valid), 144'(0));
        rst = 1'b0;
        wait_valid("t6_timeout2", 10);
        check("t6_fresh", mcf_bus.mcf_params, 144'(48'hFFFF_0000_0200));
        mcf_bus.mcf_ready = 1'b1;
        step(1);
        xoff_req = 8'h00;
        step(10);

        // refresh period
        cfg_refresh = 16'd3; xoff_req = 8'h01;
        n_acc = 0; cyc = 0;
        while (n_acc < 5 && cyc < 200) begin
            step(1);
            cyc++;
            if (mcf_bus.mcf_valid && mcf_bus.mcf_ready) begin
                acc_idx[n_acc] = cyc;
                n_acc++;
            end
        end
        check("t4_count", 144'(n_acc), 144'(5));
        if (n_acc == 5) begin
            check("t4_period_a", 144'(acc_idx[3] - acc_idx[2]), 144'(12));
            check("t4_period_b", 144'(acc_idx[4] - acc_idx[3]), 144'(12));
        end
        cfg_refresh = 16'd0;
        step(20);
        n_valid = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (mcf_bus.mcf_valid) n_valid++;
        end
        check("t4_no_refresh", 144'(n_valid), 144'(0));
        xoff_req = 8'h00;
        step(10);

`ifdef MQNIC_PFC_SCHED_LFC_EN
        cfg_lfc_mode = 1'b1;
        step(5);
        xoff_req = 8'h30;
        wait_valid("t5_timeout", 10);
        check("t5_opcode", 144'(mcf_bus.mcf_opcode), 144'(16'h0001));
        check("t5_params", mcf_bus.mcf_params, 144'(16'hFFFF));
        step(2);
        xoff_req = 8'h10;
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (mcf_bus.mcf_valid) n_valid++;
        end
        check("t5_no_frame", 144'(n_valid), 144'(0));
        xoff_req = 8'h00;
        step(10);
        cfg_lfc_mode = 1'b0;
        step(5);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)   xoff_req = 8'($urandom);
            mcf_bus.mcf_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: cfg_refresh = 16'd0;
                    1: cfg_refresh = 16'd2;
                    2: cfg_refresh = 16'd3;
                    default: cfg_refresh = 16'd5;
                endcase
            end
            if ($urandom_range(0, 149) == 0) cfg_quanta = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 49) == 0)  cfg_eth_src = {16'h0200, 32'($urandom)};
`ifdef MQNIC_PFC_SCHED_LFC_EN
            if ($urandom_range(0, 299) == 0) cfg_lfc_mode = ~cfg_lfc_mode;
`endif
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
